// File: rtl/dqsw_wl_train_pkg.sv
// Shared FSM type, direction/vote constants and lane-slice helper for the
// DQSW write-leveling training sequencer.
package dqsw_wl_train_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        STEP,
        BACK,
        NEXT,
        FIN
    } train_state_t;

    localparam int   SAMPLE_VOTES = 3;
    localparam logic DIR_INC      = 1'b1;
    localparam logic DIR_DEC      = 1'b0;

    // LSB position of a lane's field inside a packed per-lane vector.
    function automatic int lane_lsb(input int lane, input int field_w);
        return lane * field_w;
    endfunction

endpackage

// File: rtl/dqsw_wl_lane_mux.sv
// One-hot fan-out of the sequencer's scalar strobes onto the active lane,
// and selection of that lane's LATE / OUT_OF_RANGE flags.
module dqsw_wl_lane_mux
    import dqsw_wl_train_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 1
) (
    input  logic [LANE_W-1:0]    lane,
    input  logic                 load,
    input  logic                 move,
    input  logic                 dir,
    input  logic                 clear,
    input  logic [NUM_LANES-1:0] late_vec,
    input  logic [NUM_LANES-1:0] oor_vec,
    output logic [NUM_LANES-1:0] load_vec,
    output logic [NUM_LANES-1:0] move_vec,
    output logic [NUM_LANES-1:0] dir_vec,
    output logic [NUM_LANES-1:0] clear_vec,
    output logic                 late,
    output logic                 oor
);

    logic [NUM_LANES-1:0] lane_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_hit[gi]  = (lane == LANE_W'(gi));
            assign load_vec[gi]  = lane_hit[gi] & load;
            assign move_vec[gi]  = lane_hit[gi] & move;
            assign clear_vec[gi] = lane_hit[gi] & clear;
            assign dir_vec[gi]   = lane_hit[gi] & (dir == DIR_INC);
        end
    endgenerate

    assign late = |(late_vec & lane_hit);
    assign oor  = |(oor_vec & lane_hit);

endmodule

// File: rtl/dqsw_wl_train_ctrl.sv
// Multi-lane DDR3 write-leveling sweep: steps each lane's delay line until LATE,
// then backs off. Optional 2-of-3 LATE vote via DQSW_WL_TRAIN_MAJORITY_EN.
module dqsw_wl_train_ctrl
    import dqsw_wl_train_pkg::*;
#(
    parameter int NUM_LANES     = 2,
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int BACKOFF_TAPS  = 4,
    localparam int TAP_W        = $clog2(MAX_TAPS)
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST_N,
    input  logic                       TRAIN_START,
    input  logic                       TRAIN_ABORT,
    output logic                       TRAIN_BUSY,
    output logic                       TRAIN_DONE,
    output logic [NUM_LANES-1:0]       LANE_ERR,
    output logic [NUM_LANES*TAP_W-1:0] RESULT_TAP,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    train_state_t state_reg, state_next;
    logic [LANE_W-1:0]          lane_reg, lane_next;
    logic [TAP_W-1:0]           tap_reg, tap_next;
    logic [CNT_W-1:0]           settle_cnt_reg, settle_cnt_next;
    logic [TAP_W-1:0]           back_cnt_reg, back_cnt_next;
    logic                       back_gap_reg, back_gap_next;
    logic                       busy_reg;
    logic                       done_reg, done_next;
    logic                       dir_reg, dir_next;
    logic [NUM_LANES-1:0]       lane_err_reg, lane_err_next;
    logic [NUM_LANES*TAP_W-1:0] result_reg, result_next;

    logic [NUM_LANES-1:0] load_vec_reg, move_vec_reg, dir_vec_reg, clear_vec_reg;
    logic [NUM_LANES-1:0] load_vec_next, move_vec_next, dir_vec_next, clear_vec_next;
    logic                 load_s, move_s, clear_s;
    logic                 late_sel, oor_sel;
    logic                 sample_done, late_hit;

`ifdef DQSW_WL_TRAIN_MAJORITY_EN
    localparam int VOTE_MAJ = SAMPLE_VOTES / 2 + 1;
    logic [1:0] vote_idx_reg, vote_idx_next;
    logic [1:0] vote_cnt_reg, vote_cnt_next;

    assign sample_done = (vote_idx_reg == 2'(SAMPLE_VOTES - 1));
    assign late_hit    = (int'(vote_cnt_reg) + int'(late_sel)) >= VOTE_MAJ;
`else
    assign sample_done = 1'b1;
    assign late_hit    = late_sel;
`endif

    dqsw_wl_lane_mux #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_lane_mux (
        .lane      (lane_reg),
        .load      (load_s),
        .move      (move_s),
        .dir       (dir_next),
        .clear     (clear_s),
        .late_vec  (EYE_MONITOR_LATE),
        .oor_vec   (DELAY_LINE_OUT_OF_RANGE),
        .load_vec  (load_vec_next),
        .move_vec  (move_vec_next),
        .dir_vec   (dir_vec_next),
        .clear_vec (clear_vec_next),
        .late      (late_sel),
        .oor       (oor_sel)
    );

    always_comb begin
        state_next      = state_reg;
        lane_next       = lane_reg;
        tap_next        = tap_reg;
        settle_cnt_next = settle_cnt_reg;
        back_cnt_next   = back_cnt_reg;
        back_gap_next   = back_gap_reg;
        done_next       = done_reg;
        dir_next        = dir_reg;
        lane_err_next   = lane_err_reg;
        result_next     = result_reg;
        load_s          = 1'b0;
        move_s          = 1'b0;
        clear_s         = 1'b0;
`ifdef DQSW_WL_TRAIN_MAJORITY_EN
        vote_idx_next   = vote_idx_reg;
        vote_cnt_next   = vote_cnt_reg;
`endif

        if (TRAIN_ABORT && (state_reg != IDLE)) begin
            // Abort drops every strobe; results of finished lanes stay put.
            state_next = IDLE;
            dir_next   = DIR_DEC;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (TRAIN_START && !TRAIN_ABORT) begin
                        done_next     = 1'b0;
                        lane_err_next = '0;
                        result_next   = '0;
                        lane_next     = '0;
                        state_next    = LOAD;
                    end
                end
                LOAD: begin
                    load_s     = 1'b1;
                    tap_next   = '0;
                    dir_next   = DIR_DEC;
                    state_next = CLEAR;
                end
                CLEAR: begin
                    clear_s         = 1'b1;
                    settle_cnt_next = CNT_W'(SETTLE_CYCLES - 1);
                    state_next      = (SETTLE_CYCLES > 1) ? SETTLE : SAMPLE;
`ifdef DQSW_WL_TRAIN_MAJORITY_EN
                    vote_idx_next   = '0;
                    vote_cnt_next   = '0;
`endif
                end
                SETTLE: begin
                    // Leave when the decremented count hits zero.
                    settle_cnt_next = settle_cnt_reg - 1'b1;
                    if (settle_cnt_reg <= CNT_W'(1))
                        state_next = SAMPLE;
                end
                SAMPLE: begin
                    if (oor_sel) begin
                        lane_err_next[lane_reg] = 1'b1;
                        result_next[lane_lsb(int'(lane_reg), TAP_W) +: TAP_W] = tap_reg;
                        state_next = NEXT;
                    end else if (!sample_done) begin
`ifdef DQSW_WL_TRAIN_MAJORITY_EN
                        vote_idx_next = vote_idx_reg + 1'b1;
                        vote_cnt_next = vote_cnt_reg + {1'b0, late_sel};
`endif
                    end else if (late_hit) begin
                        if (int'(tap_reg) < BACKOFF_TAPS)
                            back_cnt_next = tap_reg;
                        else
                            back_cnt_next = TAP_W'(BACKOFF_TAPS);
                        back_gap_next = 1'b0;
                        dir_next      = DIR_DEC;
                        state_next    = BACK;
                    end else if (tap_reg == TAP_W'(MAX_TAPS - 1)) begin
                        lane_err_next[lane_reg] = 1'b1;
                        result_next[lane_lsb(int'(lane_reg), TAP_W) +: TAP_W] = tap_reg;
                        state_next = NEXT;
                    end else begin
                        // Direction is set a cycle ahead of the MOVE strobe.
                        dir_next   = DIR_INC;
                        state_next = STEP;
                    end
                end
                STEP: begin
                    move_s     = 1'b1;
                    tap_next   = tap_reg + 1'b1;
                    state_next = CLEAR;
                end
                BACK: begin
                    if (back_gap_reg) begin
                        back_gap_next = 1'b0;
                    end else if (back_cnt_reg != '0) begin
                        move_s        = 1'b1;
                        tap_next      = tap_reg - 1'b1;
                        back_cnt_next = back_cnt_reg - 1'b1;
                        back_gap_next = 1'b1;
                    end else begin
                        result_next[lane_lsb(int'(lane_reg), TAP_W) +: TAP_W] = tap_reg;
                        state_next = NEXT;
                    end
                end
                NEXT: begin
                    dir_next = DIR_DEC;
                    if (lane_reg == LANE_W'(NUM_LANES - 1)) begin
                        state_next = FIN;
                    end else begin
                        lane_next  = lane_reg + 1'b1;
                        state_next = LOAD;
                    end
                end
                FIN: begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_reg      <= IDLE;
            lane_reg       <= '0;
            tap_reg        <= '0;
            settle_cnt_reg <= '0;
            back_cnt_reg   <= '0;
            back_gap_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            dir_reg        <= 1'b0;
            lane_err_reg   <= '0;
            result_reg     <= '0;
            load_vec_reg   <= '0;
            move_vec_reg   <= '0;
            dir_vec_reg    <= '0;
            clear_vec_reg  <= '0;
`ifdef DQSW_WL_TRAIN_MAJORITY_EN
            vote_idx_reg   <= '0;
            vote_cnt_reg   <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            lane_reg       <= lane_next;
            tap_reg        <= tap_next;
            settle_cnt_reg <= settle_cnt_next;
            back_cnt_reg   <= back_cnt_next;
            back_gap_reg   <= back_gap_next;
            busy_reg       <= (state_next != IDLE);
            done_reg       <= done_next;
            dir_reg        <= dir_next;
            lane_err_reg   <= lane_err_next;
            result_reg     <= result_next;
            load_vec_reg   <= load_vec_next;
            move_vec_reg   <= move_vec_next;
            dir_vec_reg    <= dir_vec_next;
            clear_vec_reg  <= clear_vec_next;
`ifdef DQSW_WL_TRAIN_MAJORITY_EN
            vote_idx_reg   <= vote_idx_next;
            vote_cnt_reg   <= vote_cnt_next;
`endif
        end
    end

    assign TRAIN_BUSY              = busy_reg;
    assign TRAIN_DONE              = done_reg;
    assign LANE_ERR                = lane_err_reg;
    assign RESULT_TAP              = result_reg;
    assign DELAY_LINE_LOAD         = load_vec_reg;
    assign DELAY_LINE_MOVE         = move_vec_reg;
    assign DELAY_LINE_DIRECTION    = dir_vec_reg;
    assign EYE_MONITOR_CLEAR_FLAGS = clear_vec_reg;

endmodule

// File: tb/tb_dqsw_wl_train_ctrl.sv
// Directed + randomized bench for dqsw_wl_train_ctrl against a per-lane
// outcome model and a reactive delay-line / eye-monitor model.
module tb_dqsw_wl_train_ctrl;

    localparam int NL      = 2;
    localparam int TAP_W   = 7;
    localparam int MAXT    = 128;
    localparam int BACKOFF = 4;
    localparam int NEVER   = 1000;

    logic              FAB_CLK = 1'b0;
    logic              ARST_N;
    logic              TRAIN_START;
    logic              TRAIN_ABORT;
    logic              TRAIN_BUSY;
    logic              TRAIN_DONE;
    logic [NL-1:0]     LANE_ERR;
    logic [NL*TAP_W-1:0] RESULT_TAP;
    logic [NL-1:0]     DELAY_LINE_LOAD;
    logic [NL-1:0]     DELAY_LINE_MOVE;
    logic [NL-1:0]     DELAY_LINE_DIRECTION;
    logic [NL-1:0]     EYE_MONITOR_CLEAR_FLAGS;
    logic [NL-1:0]     EYE_MONITOR_LATE;
    logic [NL-1:0]     DELAY_LINE_OUT_OF_RANGE;

    dqsw_wl_train_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST_N                  (ARST_N),
        .TRAIN_START             (TRAIN_START),
        .TRAIN_ABORT             (TRAIN_ABORT),
        .TRAIN_BUSY              (TRAIN_BUSY),
        .TRAIN_DONE              (TRAIN_DONE),
        .LANE_ERR                (LANE_ERR),
        .RESULT_TAP              (RESULT_TAP),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int total = 0;
    int bad   = 0;

    // Scenario knobs (written by the stimulus block only).
    int late_at [NL];
    int oor_at  [NL];
    int glitch_tap;

    // Delay-line / eye-monitor model and cumulative observations (monitor only).
    int m_tap   [NL];
    int inc_tot [NL];
    int dec_tot [NL];
    int strobe_viol_tot = 0;
    int dir_viol_tot    = 0;
    int strobe_cyc_tot  = 0;
    int cyc             = 0;
    logic [NL-1:0] prev_dir;

    always @(negedge FAB_CLK) begin
        cyc++;
        if ($countones(DELAY_LINE_LOAD) > 1 || $countones(DELAY_LINE_MOVE) > 1 ||
            $countones(DELAY_LINE_DIRECTION) > 1 || $countones(EYE_MONITOR_CLEAR_FLAGS) > 1)
            strobe_viol_tot++;
        if ((DELAY_LINE_LOAD | DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS) != '0)
            strobe_cyc_tot++;
        for (int i = 0; i < NL; i++) begin
            if (DELAY_LINE_LOAD[i] === 1'b1)
                m_tap[i] = 0;
            if (DELAY_LINE_MOVE[i] === 1'b1) begin
                if (DELAY_LINE_DIRECTION[i] !== prev_dir[i])
                    dir_viol_tot++;
                if (DELAY_LINE_DIRECTION[i] === 1'b1) begin
                    inc_tot[i]++;
                    m_tap[i]++;
                end else begin
                    dec_tot[i]++;
                    m_tap[i]--;
                end
            end
        end
        prev_dir = DELAY_LINE_DIRECTION;
        for (int i = 0; i < NL; i++) begin
            EYE_MONITOR_LATE[i] = (m_tap[i] >= late_at[i]) ||
                                  ((m_tap[i] == glitch_tap) && (cyc % 3 == 0));
            DELAY_LINE_OUT_OF_RANGE[i] = (m_tap[i] >= oor_at[i]);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outcome of one lane's sweep, straight from the training rules.
    function automatic void lane_expect(input int t, input int o,
                                        output int res, output int err,
                                        output int inc, output int dec);
        if (o <= t && o <= MAXT - 1) begin
            res = o; err = 1; inc = o; dec = 0;
        end else if (t <= MAXT - 1) begin
            dec = (t < BACKOFF) ? t : BACKOFF;
            res = t - dec; err = 0; inc = t;
        end else begin
            res = MAXT - 1; err = 1; inc = MAXT - 1; dec = 0;
        end
    endfunction

    task automatic run_train(input string tag, input int t0, input int t1,
                             input int o0, input int o1);
        int res, err, inc, dec, c;
        int inc_snap [NL];
        int dec_snap [NL];
        int sv, dv;
        int tv [NL];
        int ov [NL];
        logic [NL*TAP_W-1:0] exp_res;
        logic [NL-1:0]       exp_err;
        tv[0] = t0; tv[1] = t1; ov[0] = o0; ov[1] = o1;
        for (int i = 0; i < NL; i++) begin
            late_at[i] = tv[i];
            oor_at[i]  = ov[i];
        end
        @(negedge FAB_CLK);
        for (int i = 0; i < NL; i++) begin
            inc_snap[i] = inc_tot[i];
            dec_snap[i] = dec_tot[i];
        end
        sv = strobe_viol_tot;
        dv = dir_viol_tot;
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        check({tag, "_busy_after_start"}, TRAIN_BUSY, 1);
        check({tag, "_done_cleared"}, TRAIN_DONE, 0);
        repeat (5) @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        c = 0;
        while (TRAIN_DONE !== 1'b1 && c < 8000) begin
            @(negedge FAB_CLK);
            c++;
        end
        check({tag, "_done"}, TRAIN_DONE, 1);
        check({tag, "_busy_end"}, TRAIN_BUSY, 0);
        exp_res = '0;
        exp_err = '0;
        for (int i = 0; i < NL; i++) begin
            lane_expect(tv[i], ov[i], res, err, inc, dec);
            exp_res[i*TAP_W +: TAP_W] = TAP_W'(res);
            exp_err[i] = (err != 0);
            check($sformatf("%s_inc_moves_l%0d", tag, i), 64'(inc_tot[i] - inc_snap[i]), 64'(inc));
            check($sformatf("%s_dec_moves_l%0d", tag, i), 64'(dec_tot[i] - dec_snap[i]), 64'(dec));
        end
        check({tag, "_result_tap"}, RESULT_TAP, exp_res);
        check({tag, "_lane_err"}, LANE_ERR, exp_err);
        check({tag, "_onehot"}, 64'(strobe_viol_tot - sv), 0);
        check({tag, "_dir_stable"}, 64'(dir_viol_tot - dv), 0);
        $display("run %s: lanes T=%0d/%0d OOR=%0d/%0d result=%0h err=%b cycles=%0d",
                 tag, t0, t1, o0, o1, RESULT_TAP, LANE_ERR, c);
    endtask

    initial begin
        int c, sc, t0, t1, o0, o1;
        for (int i = 0; i < NL; i++) begin
            late_at[i] = NEVER;
            oor_at[i]  = NEVER;
            m_tap[i]   = 0;
            inc_tot[i] = 0;
            dec_tot[i] = 0;
        end
        glitch_tap  = -1;
        ARST_N      = 1'b0;
        TRAIN_START = 1'b0;
        TRAIN_ABORT = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        check("rst_busy", TRAIN_BUSY, 0);
        check("rst_done", TRAIN_DONE, 0);
        check("rst_lane_err", LANE_ERR, 0);
        check("rst_result", RESULT_TAP, 0);
        check("rst_strobes", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                              EYE_MONITOR_CLEAR_FLAGS}, 0);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);

        run_train("basic", 20, 37, NEVER, NEVER);
        run_train("tap0", 0, 37, NEVER, NEVER);
        run_train("small_t", 2, 5, NEVER, NEVER);
        run_train("no_late", 20, NEVER, NEVER, NEVER);
        run_train("oor", NEVER, 25, 50, NEVER);

        // START and ABORT together from idle: abort wins, DONE untouched.
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        TRAIN_ABORT = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        TRAIN_ABORT = 1'b0;
        check("start_abort_busy", TRAIN_BUSY, 0);
        check("start_abort_done", TRAIN_DONE, 1);
        $display("start+abort together: busy=%b done=%b", TRAIN_BUSY, TRAIN_DONE);

        // Abort while lane 1 is settling.
        late_at[0] = 20;
        late_at[1] = 37;
        oor_at[0]  = NEVER;
        oor_at[1]  = NEVER;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        c = 0;
        while (DELAY_LINE_LOAD[1] !== 1'b1 && c < 3000) begin
            @(negedge FAB_CLK);
            c++;
        end
        check("abort_reach_lane1", DELAY_LINE_LOAD[1], 1);
        repeat (2) @(negedge FAB_CLK);
        TRAIN_ABORT = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_ABORT = 1'b0;
        check("abort_busy", TRAIN_BUSY, 0);
        check("abort_done", TRAIN_DONE, 0);
        check("abort_strobes", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}, 0);
        sc = strobe_cyc_tot;
        repeat (60) @(negedge FAB_CLK);
        check("abort_quiet", 64'(strobe_cyc_tot - sc), 0);
        check("abort_keep_lane0", RESULT_TAP[TAP_W-1:0], 16);
        check("abort_lane_err", LANE_ERR, 0);
        $display("abort in lane1 settle: busy=%b done=%b result=%0h", TRAIN_BUSY, TRAIN_DONE, RESULT_TAP);
        run_train("retrain", 20, 37, NEVER, NEVER);

        for (int r = 0; r < 4; r++) begin
            t0 = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 60));
            t1 = int'($urandom_range(0, 60));
            o0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : NEVER;
            o1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : NEVER;
            run_train($sformatf("rand%0d", r), t0, t1, o0, o1);
        end

`ifdef DQSW_WL_TRAIN_MAJORITY_EN
        glitch_tap = 10;
        run_train("majority_glitch", 15, 15, NEVER, NEVER);
        glitch_tap = -1;
`endif

        // Asynchronous reset in the middle of a sweep.
        late_at[0] = 40;
        late_at[1] = 40;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        repeat (100) @(negedge FAB_CLK);
        #2 ARST_N = 1'b0;
        #1;
        check("arst_busy", TRAIN_BUSY, 0);
        check("arst_done", TRAIN_DONE, 0);
        check("arst_result", RESULT_TAP, 0);
        check("arst_strobes", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                               EYE_MONITOR_CLEAR_FLAGS}, 0);
        $display("async reset mid-sweep: busy=%b done=%b result=%0h", TRAIN_BUSY, TRAIN_DONE, RESULT_TAP);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        run_train("after_arst", 9, 3, NEVER, NEVER);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
